// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential shift-add 16x16 multiplier that borrows a shared ALU for its add and shift steps
// Define MUL_EARLY_TERM_EN to skip zero-bit ADD cycles and stop as soon as the multiplier is exhausted.
package opcodes;
    typedef enum logic [3:0] {FnA, FnB, FnADD, FnSUB, FnAND, FnOR, FnXOR, FnLSL, FnLSR} alu_functions_t;
    localparam int FLAGS_C = 1;
endpackage

module alu_mul_seq
    import opcodes::*;
(
    input  logic           Clock,
    input  logic           nReset,
    input  logic           Start,
    input  logic [15:0]    Multiplicand,
    input  logic [15:0]    Multiplier,
    output logic           Busy,
    output logic           Done,
    output logic [15:0]    Product,
    output logic           Overflow,
    output alu_functions_t AluOp,
    output logic [15:0]    AluOp1,
    output logic [15:0]    AluOp2,
    output logic           AluCarryIn,
    input  logic [15:0]    AluResult,
    input  logic [3:0]     AluFlags
);
    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [15:0] acc, areg, breg, breg_sh;
    logic ovf;
    logic [3:0] iter;
    logic unused_bits;

    assign breg_sh = breg >> 1;
    assign unused_bits = ^{AluFlags, iter};

    always_comb begin
        state_nx = state;
        AluOp = FnA;
        AluOp1 = acc;
        AluOp2 = '0;
        case (state)
            IDLE: begin
`ifdef MUL_EARLY_TERM_EN
                if (Start) state_nx = (Multiplier == '0) ? DONE : Multiplier[0] ? ADD : SHIFT;
`else
                if (Start) state_nx = ADD;
`endif
            end
            ADD: begin
                // Without early termination a zero multiplier bit still spends an ADD cycle as a pass-through
                AluOp = breg[0] ? FnADD : FnA;
                AluOp2 = areg;
                state_nx = SHIFT;
            end
            SHIFT: begin
                AluOp = FnLSL;
                AluOp1 = areg;
                AluOp2 = 16'd1;
`ifdef MUL_EARLY_TERM_EN
                state_nx = (breg_sh == '0) ? DONE : breg_sh[0] ? ADD : SHIFT;
`else
                state_nx = (iter == 4'd15) ? DONE : ADD;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            acc <= '0;
            areg <= '0;
            breg <= '0;
            ovf <= 1'b0;
            iter <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && Start) begin
                areg <= Multiplicand;
                breg <= Multiplier;
                acc <= '0;
                ovf <= 1'b0;
                iter <= '0;
            end
            if (state == ADD) begin
                acc <= AluResult;
                ovf <= ovf | (breg[0] & AluFlags[FLAGS_C]);
            end
            if (state == SHIFT) begin
                areg <= AluResult;
                breg <= breg_sh;
                iter <= iter + 4'd1;
                // A multiplicand bit shifted out while multiplier bits remain is lost product weight
                if (areg[15] && breg_sh != '0) ovf <= 1'b1;
            end
        end
    end

    assign Busy = (state == ADD) || (state == SHIFT);
    assign Done = (state == DONE);
    assign Product = acc;
    assign Overflow = ovf;
    assign AluCarryIn = 1'b0;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized scoreboard bench for alu_mul_seq with a behavioural ALU and product model
module tb_alu_mul_seq;
    import opcodes::*;
    logic Clock = 0, nReset = 0, Start = 0;
    logic [15:0] Multiplicand = 0, Multiplier = 0;
    logic Busy, Done, Overflow, AluCarryIn;
    logic [15:0] Product, AluOp1, AluOp2, AluResult;
    alu_functions_t AluOp;
    logic [3:0] AluFlags;
    logic [16:0] sum;
    int compared = 0, mismatched = 0, busy_cnt = 0;

    typedef struct packed {logic [15:0] p; logic o; logic [31:0] cyc;} exp_t;
    exp_t sb[$];

    alu_mul_seq dut (.Clock(Clock), .nReset(nReset), .Start(Start), .Multiplicand(Multiplicand),
        .Multiplier(Multiplier), .Busy(Busy), .Done(Done), .Product(Product), .Overflow(Overflow),
        .AluOp(AluOp), .AluOp1(AluOp1), .AluOp2(AluOp2), .AluCarryIn(AluCarryIn),
        .AluResult(AluResult), .AluFlags(AluFlags));

    always #5 Clock = ~Clock;

    always_comb begin
        sum = {1'b0, AluOp1} + {1'b0, AluOp2};
        AluResult = AluOp1;
        AluFlags = '0;
        if (AluOp == FnADD) begin
            AluResult = sum[15:0];
            AluFlags[FLAGS_C] = sum[16];
        end else if (AluOp == FnLSL) begin
            AluResult = AluOp1 << AluOp2[3:0];
            AluFlags[FLAGS_C] = (AluOp2[3:0] == 4'd1) & AluOp1[15];
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [31:0] full;
        full = {16'b0, a} * {16'b0, b};
        e.p = full[15:0];
        e.o = |full[31:16];
`ifdef MUL_EARLY_TERM_EN
        e.cyc = 0;
        for (int i = 0; i < 16; i++)
            if ((b >> i) != 0) e.cyc = e.cyc + 1 + 32'(b[i]);
`else
        e.cyc = 32;
`endif
        return e;
    endfunction

    always @(negedge Clock or negedge nReset) begin
        if (!nReset) busy_cnt = 0;
        else begin
            if (Busy) busy_cnt++;
            if (Done) begin
                if (sb.size() == 0) chk("unexpected_done", 32'(Done), 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", 32'(Product), 32'(e.p));
                    chk("overflow", 32'(Overflow), 32'(e.o));
                    chk("busy_cycles", busy_cnt, e.cyc);
                    chk("carry_in", 32'(AluCarryIn), 0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic run(input logic [15:0] a, input logic [15:0] b, input bit pulse_busy, input bit poke_done);
        exp_t e;
        int n;
        e = model(a, b);
        sb.push_back(e);
        Start = 1; Multiplicand = a; Multiplier = b;
        @(posedge Clock); #1;
        Start = 0; Multiplicand = 16'($urandom); Multiplier = 16'($urandom);
        if (pulse_busy) begin
            repeat (3) @(posedge Clock);
            #1 Start = 1;
            @(posedge Clock); #1 Start = 0;
        end
        n = 0;
        do begin @(negedge Clock); n++; end while (!Done && n < 100);
        if (!Done) chk("done_timeout", 32'(Done), 1);
        if (poke_done) begin
            Start = 1; Multiplicand = 16'($urandom); Multiplier = 16'($urandom | 1);
        end
        @(posedge Clock); #1;
        Start = 0;
        chk("held_product", 32'(Product), 32'(e.p));
        chk("held_overflow", 32'(Overflow), 32'(e.o));
        if (poke_done) begin
            repeat (40) @(negedge Clock);
            chk("done_start_ignored", 32'(Busy), 0);
            @(posedge Clock); #1;
        end
    endtask

    task automatic reset_mid_op();
        int n;
        Start = 1; Multiplicand = 16'($urandom | 1); Multiplier = 16'hFFFF;
        @(posedge Clock); #1 Start = 0;
        n = 0;
        do begin @(negedge Clock); n++; end while (!(AluOp == FnADD && Product != 0) && n < 100);
        chk("reach_add", 32'(AluOp == FnADD), 1);
        #1 nReset = 0;
        #1;
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_product", 32'(Product), 0);
        chk("rst_overflow", 32'(Overflow), 0);
        sb.delete();
        @(posedge Clock); #1 nReset = 1;
    endtask

    initial begin
        repeat (2) @(posedge Clock);
        #1;
        chk("init_busy", 32'(Busy), 0);
        chk("init_done", 32'(Done), 0);
        chk("init_product", 32'(Product), 0);
        chk("init_overflow", 32'(Overflow), 0);
        @(posedge Clock); #1 nReset = 1;
        run(16'd7, 16'd6, 0, 0);
        run(16'h1234, 16'h0000, 0, 0);
        run(16'h0100, 16'h0100, 0, 0);
        run(16'hFFFF, 16'hFFFF, 0, 0);
        run(16'd3, 16'd5, 0, 0);
        run(16'h0000, 16'hFFFF, 0, 0);
        run(16'h00FF, 16'h0101, 0, 0);
        run(16'h1234, 16'h8000 | 16'($urandom), 1, 0);
        run(16'($urandom), 16'($urandom), 0, 1);
        reset_mid_op();
        run(16'd9, 16'd11, 0, 0);
        for (int i = 0; i < 30; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 3 == 0) begin a = a >> (i % 16); b = b >> (15 - i % 16); end
            run(a, b, 0, 0);
        end
        repeat (2) @(posedge Clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
